// File: rtl/commit_select_if.sv
// Bundle of the issue/completion/commit signals between the hazard stage,
// the execution lanes and the in-order commit buffer.
// Handshake semantics: every request (I_Req_Issue, I_Done_S, I_Done_V) is a
// single-cycle strobe with no ready/backpressure; the accompanying number is
// sampled on the same rising edge. O_Req_Commit is a one-cycle pulse whose
// O_Commit_No is valid only while the pulse is high.
interface commit_select_if #(
  parameter int DEPTH_BUFF = 16
);
  localparam int WIDTH_BUFF = $clog2(DEPTH_BUFF);

  logic                  I_Req_Issue;
  logic [WIDTH_BUFF-1:0] I_Issue_No;
  logic                  I_Done_S;
  logic [WIDTH_BUFF-1:0] I_Done_S_No;
  logic                  I_Done_V;
  logic [WIDTH_BUFF-1:0] I_Done_V_No;
  logic                  O_Req_Commit;
  logic [WIDTH_BUFF-1:0] O_Commit_No;
  logic                  O_Full;
  logic                  O_Empty;
  logic [WIDTH_BUFF:0]   O_Num;
  logic                  O_Err;

  // Issue/execution side: drives requests, observes commit status.
  modport master (
    output I_Req_Issue, I_Issue_No, I_Done_S, I_Done_S_No, I_Done_V, I_Done_V_No,
    input  O_Req_Commit, O_Commit_No, O_Full, O_Empty, O_Num, O_Err
  );

  // Commit buffer side.
  modport slave (
    input  I_Req_Issue, I_Issue_No, I_Done_S, I_Done_S_No, I_Done_V, I_Done_V_No,
    output O_Req_Commit, O_Commit_No, O_Full, O_Empty, O_Num, O_Err
  );
endinterface

// File: rtl/commit_select.sv
// In-order commit buffer: tracks issued instruction numbers, absorbs
// out-of-order completions from the scalar and vector paths and retires at
// most one instruction per cycle in issue order, pulsing the retired number
// back to the hazard stage. All outputs are registered.
module commit_select #(
  parameter int DEPTH_BUFF = 16
) (
  input  logic             clock,
  input  logic             reset,
  commit_select_if.slave   bus
);
  localparam int WIDTH_BUFF = $clog2(DEPTH_BUFF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } entry_e;

  entry_e                entry_q [DEPTH_BUFF];
  entry_e                entry_d [DEPTH_BUFF];
  logic [WIDTH_BUFF-1:0] head_q, head_d;
  logic [WIDTH_BUFF-1:0] tail_q, tail_d;
  logic [WIDTH_BUFF:0]   count_q, count_d;
  logic                  commit_q, commit_d;
  logic [WIDTH_BUFF-1:0] commit_no_q, commit_no_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  err_q, err_d;

  logic issue_ok, issue_bad;
  logic s_ok, s_bad, v_ok, v_bad, dual_same;
  logic head_hit, commit_fire;

  // Per-entry state update, retirement decision and status next-state.
  always_comb begin
    entry_d     = entry_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    commit_d    = 1'b0;
    commit_no_d = commit_no_q;

    // Full is judged on the registered (pre-edge) count, so a commit in the
    // same cycle never makes room for an issue.
    issue_ok  = bus.I_Req_Issue && !full_q && (bus.I_Issue_No == tail_q);
    issue_bad = bus.I_Req_Issue && !issue_ok;

    // Completions look at the registered state, so completing the number
    // being issued this cycle sees IDLE and is rejected.
    s_ok      = bus.I_Done_S && (entry_q[bus.I_Done_S_No] == ST_ISSUED);
    s_bad     = bus.I_Done_S && !s_ok;
    v_ok      = bus.I_Done_V && (entry_q[bus.I_Done_V_No] == ST_ISSUED);
    v_bad     = bus.I_Done_V && !v_ok;
    dual_same = bus.I_Done_S && bus.I_Done_V && (bus.I_Done_S_No == bus.I_Done_V_No);

    if (s_ok) entry_d[bus.I_Done_S_No] = ST_DONE;
    if (v_ok) entry_d[bus.I_Done_V_No] = ST_DONE;

    // Head retires if already DONE or completed this very cycle (bypass).
    head_hit    = (s_ok && (bus.I_Done_S_No == head_q)) ||
                  (v_ok && (bus.I_Done_V_No == head_q));
    commit_fire = (entry_q[head_q] == ST_DONE) || head_hit;

    if (commit_fire) begin
      entry_d[head_q] = ST_IDLE;
      head_d          = head_q + 1'b1;
      commit_d        = 1'b1;
      commit_no_d     = head_q;
    end

    // Tail can only alias the committing head when full, and then the issue
    // is rejected, so this write never collides with the retirement above.
    if (issue_ok) begin
      entry_d[tail_q] = ST_ISSUED;
      tail_d          = tail_q + 1'b1;
    end

    if (issue_ok && !commit_fire)      count_d = count_q + 1'b1;
    else if (!issue_ok && commit_fire) count_d = count_q - 1'b1;

    full_d  = (count_d == (WIDTH_BUFF+1)'(DEPTH_BUFF));
    empty_d = (count_d == '0);
    err_d   = err_q | issue_bad | s_bad | v_bad | dual_same;
  end

  // State and output registers; reset drops every tracked entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_BUFF; i++) entry_q[i] <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      commit_q    <= commit_d;
      commit_no_q <= commit_no_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      err_q       <= err_d;
    end
  end

  assign bus.O_Req_Commit = commit_q;
  assign bus.O_Commit_No  = commit_no_q;
  assign bus.O_Full       = full_q;
  assign bus.O_Empty      = empty_q;
  assign bus.O_Num        = count_q;
  assign bus.O_Err        = err_q;
endmodule

// File: tb/tb_commit_select.sv
// Bench for commit_select: table-driven directed rows, hand-written
// multi-cycle sequences and randomized traffic, all checked against a
// queue-based model of in-order retirement.
module tb_commit_select;
  localparam int DEPTH = 16;
  localparam int W     = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  commit_select_if #(.DEPTH_BUFF(DEPTH)) bus ();
  commit_select #(.DEPTH_BUFF(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding instructions oldest-first; done_m marks completed ones.
  int unsigned order_q[$];
  bit          done_m [DEPTH];
  int unsigned next_no;
  bit          err_m;
  bit          exp_commit;
  int unsigned exp_no;

  function automatic bit is_pending(input int unsigned n);
    foreach (order_q[k]) if (order_q[k] == n) return !done_m[n];
    return 1'b0;
  endfunction

  task automatic model_reset();
    order_q.delete();
    for (int i = 0; i < DEPTH; i++) done_m[i] = 1'b0;
    next_no    = 0;
    err_m      = 1'b0;
    exp_commit = 1'b0;
  endtask

  task automatic model_step(input bit ri, input int unsigned in_no,
                            input bit ds, input int unsigned sn,
                            input bit dv, input int unsigned vn);
    bit s_good, v_good, accept;
    accept = ri && (order_q.size() < DEPTH) && (in_no == next_no);
    if (ri && !accept) err_m = 1'b1;
    s_good = ds && is_pending(sn);
    v_good = dv && is_pending(vn);
    if (ds && !s_good) err_m = 1'b1;
    if (dv && !v_good) err_m = 1'b1;
    if (ds && dv && sn == vn) err_m = 1'b1;
    if (s_good) done_m[sn] = 1'b1;
    if (v_good) done_m[vn] = 1'b1;
    exp_commit = 1'b0;
    if (order_q.size() > 0 && done_m[order_q[0]]) begin
      exp_commit = 1'b1;
      exp_no     = order_q[0];
      done_m[exp_no] = 1'b0;
      void'(order_q.pop_front());
    end
    if (accept) begin
      order_q.push_back(next_no);
      next_no = (next_no + 1) % DEPTH;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit ri, input int unsigned in_no,
                       input bit ds, input int unsigned sn,
                       input bit dv, input int unsigned vn);
    logic [W-1:0] a, b, c;
    a = in_no[W-1:0]; b = sn[W-1:0]; c = vn[W-1:0];
    bus.I_Req_Issue = ri; bus.I_Issue_No  = a;
    bus.I_Done_S    = ds; bus.I_Done_S_No = b;
    bus.I_Done_V    = dv; bus.I_Done_V_No = c;
    model_step(ri, in_no, ds, sn, dv, vn);
    @(posedge clock); #1;
    bus.I_Req_Issue = 1'b0; bus.I_Done_S = 1'b0; bus.I_Done_V = 1'b0;
    chk("commit_pulse", 32'(bus.O_Req_Commit), 32'(exp_commit));
    if (exp_commit) chk("commit_no", 32'(bus.O_Commit_No), exp_no);
    chk("num",   32'(bus.O_Num),   order_q.size());
    chk("full",  32'(bus.O_Full),  32'(order_q.size() == DEPTH));
    chk("empty", 32'(bus.O_Empty), 32'(order_q.size() == 0));
    chk("err",   32'(bus.O_Err),   32'(err_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_commit", 32'(bus.O_Req_Commit), 0);
    chk("rst_no",     32'(bus.O_Commit_No),  0);
    chk("rst_full",   32'(bus.O_Full),       0);
    chk("rst_empty",  32'(bus.O_Empty),      1);
    chk("rst_num",    32'(bus.O_Num),        0);
    chk("rst_err",    32'(bus.O_Err),        0);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit           rst;
    bit           ri;
    int unsigned  in_no;
    bit           ds;
    int unsigned  sn;
    bit           dv;
    int unsigned  vn;
    bit           ec;
    int unsigned  en;
    int unsigned  num;
    bit           ee;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bus.I_Req_Issue = 1'b0; bus.I_Issue_No  = '0;
    bus.I_Done_S    = 1'b0; bus.I_Done_S_No = '0;
    bus.I_Done_V    = 1'b0; bus.I_Done_V_No = '0;
    reset = 1'b0;
    model_reset();
    #12;

    // rst, ri, in, ds, sn, dv, vn, exp_commit, exp_no, exp_num, exp_err
    // In-order retirement.
    tbl.push_back('{1,1,0, 0,0, 0,0, 0,0,1,0});
    tbl.push_back('{0,1,1, 0,0, 0,0, 0,0,2,0});
    tbl.push_back('{0,1,2, 0,0, 0,0, 0,0,3,0});
    tbl.push_back('{0,0,0, 1,0, 0,0, 1,0,2,0});
    tbl.push_back('{0,0,0, 1,2, 1,1, 1,1,1,0});
    tbl.push_back('{0,0,0, 0,0, 0,0, 1,2,0,0});
    tbl.push_back('{0,0,0, 0,0, 0,0, 0,0,0,0});
    // Out-of-order completion, in-order retirement.
    tbl.push_back('{1,1,0, 0,0, 0,0, 0,0,1,0});
    tbl.push_back('{0,1,1, 0,0, 0,0, 0,0,2,0});
    tbl.push_back('{0,1,2, 0,0, 0,0, 0,0,3,0});
    tbl.push_back('{0,1,3, 0,0, 0,0, 0,0,4,0});
    tbl.push_back('{0,0,0, 1,3, 0,0, 0,0,4,0});
    tbl.push_back('{0,0,0, 0,0, 1,2, 0,0,4,0});
    tbl.push_back('{0,0,0, 1,1, 0,0, 0,0,4,0});
    tbl.push_back('{0,0,0, 1,0, 0,0, 1,0,3,0});
    tbl.push_back('{0,0,0, 0,0, 0,0, 1,1,2,0});
    tbl.push_back('{0,0,0, 0,0, 0,0, 1,2,1,0});
    tbl.push_back('{0,0,0, 0,0, 0,0, 1,3,0,0});
    tbl.push_back('{0,0,0, 0,0, 0,0, 0,0,0,0});
    // Completion of an IDLE entry.
    tbl.push_back('{1,0,0, 1,5, 0,0, 0,0,0,1});
    tbl.push_back('{0,0,0, 0,0, 0,0, 0,0,0,1});
    // Both ports complete the same entry: one commit, error flagged.
    tbl.push_back('{1,1,0, 0,0, 0,0, 0,0,1,0});
    tbl.push_back('{0,0,0, 1,0, 1,0, 1,0,0,1});
    tbl.push_back('{0,0,0, 0,0, 0,0, 0,0,0,1});
    // Issue and completion of the same number in one cycle.
    tbl.push_back('{1,1,0, 1,0, 0,0, 0,0,1,1});
    tbl.push_back('{0,0,0, 1,0, 0,0, 1,0,0,1});

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      cycle(tbl[i].ri, tbl[i].in_no, tbl[i].ds, tbl[i].sn, tbl[i].dv, tbl[i].vn);
      chk($sformatf("vec%0d_commit", i), 32'(bus.O_Req_Commit), 32'(tbl[i].ec));
      if (tbl[i].ec) chk($sformatf("vec%0d_no", i), 32'(bus.O_Commit_No), tbl[i].en);
      chk($sformatf("vec%0d_num", i), 32'(bus.O_Num), tbl[i].num);
      chk($sformatf("vec%0d_err", i), 32'(bus.O_Err), 32'(tbl[i].ee));
    end

    // Reset mid-run with 5 entries in flight: nothing commits afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, i, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 0, 0);
    do_reset();
    idle(4);
    chk("midrst_num", 32'(bus.O_Num), 0);
    chk("midrst_nocommit", 32'(bus.O_Req_Commit), 0);

    // Fill, overflow, wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 0, 0, 0, 0);
    chk("fill_full", 32'(bus.O_Full), 1);
    chk("fill_num",  32'(bus.O_Num), 16);
    cycle(1, 0, 0, 0, 0, 0);
    chk("ovf_err", 32'(bus.O_Err), 1);
    chk("ovf_num", 32'(bus.O_Num), 16);
    // Issue while full with a commit in the same cycle is still rejected.
    cycle(1, 0, 1, 0, 0, 0);
    chk("fullcommit_num", 32'(bus.O_Num), 15);
    chk("fullcommit_no",  32'(bus.O_Commit_No), 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("wrap_num",  32'(bus.O_Num), 16);
    chk("wrap_full", 32'(bus.O_Full), 1);
    // Drain: complete everything in reverse; retires 1..15 then 0.
    for (int i = DEPTH - 1; i >= 1; i--) cycle(0, 0, 1, i, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(DEPTH + 2);
    chk("drain_empty", 32'(bus.O_Empty), 1);

    // Simultaneous issue and commit at 8 occupied.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, i, 0, 0, 0, 0);
    cycle(1, 8, 1, 0, 0, 0);
    chk("simul_num", 32'(bus.O_Num), 8);
    chk("simul_commit", 32'(bus.O_Req_Commit), 1);
    chk("simul_no", 32'(bus.O_Commit_No), 0);
    idle(2);

    // Randomized traffic against the model, in a few load mixes.
    for (int phase = 0; phase < 3; phase++) begin
      int issue_pct;
      int done_pct;
      do_reset();
      issue_pct = (phase == 1) ? 85 : 60;
      done_pct  = (phase == 1) ? 20 : 45;
      for (int n = 0; n < 1200; n++) begin
        bit ri, ds, dv;
        int unsigned in_no, sn, vn;
        ri    = ($urandom_range(0, 99) < issue_pct);
        in_no = ($urandom_range(0, 29) == 0 && phase != 0) ? $urandom_range(0, DEPTH-1) : next_no;
        ds    = ($urandom_range(0, 99) < done_pct);
        dv    = ($urandom_range(0, 99) < done_pct);
        if (order_q.size() > 0 && ($urandom_range(0, 19) != 0 || phase == 0))
          sn = order_q[$urandom_range(0, order_q.size() - 1)];
        else
          sn = $urandom_range(0, DEPTH-1);
        if (order_q.size() > 0 && ($urandom_range(0, 19) != 0 || phase == 0))
          vn = order_q[$urandom_range(0, order_q.size() - 1)];
        else
          vn = $urandom_range(0, DEPTH-1);
        cycle(ri, in_no, ds, sn, dv, vn);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
